alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

- Multi-cycle unsigned multiply/divide sequencer that reuses the shared 32-bit ALU instead of adding a dedicated multiplier or divider.
- Accepts a MULTU or DIVU request and drives the ALU add/subtract port for 32 iterations.
- Accumulates the result in internal HI/LO registers and signals completion with a one-cycle done pulse.
- Sits beside the ALU in the EX stage and owns the ALU operand and control inputs while busy.

## Interface
Parameters:
- None.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  request strobe; sampled when not busy.
- op_i  input  1  0 = MULTU, 1 = DIVU.
- a_i  input  32  multiplicand / dividend.
- b_i  input  32  multiplier / divisor.
- alu_src1_o  output  32  ALU operand 1.
- alu_src2_o  output  32  ALU operand 2.
- alu_ctrl_o  output  4  ALU control: 4'b0010 ADD, 4'b0110 SUB.
- alu_result_i  input  32  ALU result, combinational from src/ctrl.
- busy_o  output  1  high during iterations.
- done_o  output  1  one-cycle completion pulse.
- hi_o  output  32  HI register: product[63:32] or remainder.
- lo_o  output  32  LO register: product[31:0] or quotient.
- dz_o  output  1  divide-by-zero flag, sticky until the next accepted start.

## Operation
States (2-bit): IDLE, MUL, DIV, DONE; 5-bit iteration counter cnt.

Accept:
- start_i=1 in IDLE or DONE.
- Latches operand M/D=b_i, sets HI=0, LO=a_i, cnt=0, dz_o=0.
- Next state is MUL (op_i=0) or DIV (op_i=1).

MUL cycle:
- Drive src1=HI, src2=(LO[0] ? M : 0), ctrl ADD.
- carry = (alu_result_i < HI), unsigned.
- {HI,LO} <= {carry, alu_result_i, LO[31:1]}.

DIV cycle (restoring):
- sh = {HI[30:0], LO[31]}.
- Drive src1=sh, src2=D, ctrl SUB.
- ge = HI[31] | (sh >= D), unsigned.
- HI <= ge ? alu_result_i : sh; LO <= {LO[30:0], ge}.
- The ALU's 32-bit wrap gives the correct difference when HI[31]=1.

Iteration exit:
- cnt increments each MUL/DIV cycle.
- When cnt==31, that update is the last one and the next state is DONE.

DONE:
- done_o=1 for exactly one cycle; busy_o=0.
- Next state is IDLE unless start_i is accepted.

DIVU with b_i==0:
- No iterations; go straight to DONE.
- HI=a_i, LO=32'hFFFFFFFF, dz_o=1.

Other rules:
- IDLE/DONE drive src1=src2=0, ctrl=4'b0000.
- start_i while busy is ignored; no queueing.
- a_i/b_i are don't-care after acceptance.
- hi_o/lo_o show intermediate values while busy; they are valid from done_o until the next accept.

## Timing
- Reset (async, rst_n=0): state IDLE, cnt=0, busy_o=0, done_o=0, dz_o=0, hi_o=lo_o=0, alu_src1_o=alu_src2_o=0, alu_ctrl_o=0.
- Reset takes effect immediately and aborts any operation; outputs return to reset values without waiting for a clock.
- Start sampled at edge N. busy_o is high in cycles N+1..N+32. done_o is high in cycle N+33; HI/LO are final then.
- Divide-by-zero: done_o is high in cycle N+1; busy_o never rises.
- Back-to-back: start_i during the DONE cycle is accepted. The next operation's busy_o rises the following cycle, with no idle gap.
- ALU outputs are registered-state driven (Moore); alu_result_i is consumed in the same cycle.

## Configuration
- Macro: MULDIV_DIV_EN.
- Defined: full DIVU support as specified.
- Undefined:
  - DIV state and compare logic are removed.
  - An accepted op_i=1 goes directly to DONE with HI=LO=0 and dz_o=0.
  - alu_ctrl_o never drives SUB.
  - MULTU behaviour is unchanged.

## Test plan
- Reset mid-MUL: assert rst_n=0 at busy cycle 10 -> all outputs 0 immediately; after release, start MULTU 3×5 -> hi=0, lo=15, done at N+33.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; alu_ctrl_o=4'b0010 on all 32 busy cycles.
- DIVU 100/7 -> lo=14, hi=2, dz_o=0. DIVU 32'hFFFFFFFF/1 -> lo=32'hFFFFFFFF, hi=0. DIVU 32'h80000000/32'hFFFFFFFF -> lo=0, hi=32'h80000000.
- DIVU 1234/0 -> done at N+1, busy_o never 1, hi=1234, lo=32'hFFFFFFFF, dz_o=1. A following MULTU start clears dz_o.
- start_i held high continuously with alternating op_i -> new operation accepted only on DONE cycles; the busy_o pulse train is 32 high, 1 low.
- MULDIV_DIV_EN undefined: DIVU 100/7 -> done at N+1, hi=lo=0, dz_o=0.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the shared 32-bit ALU adder.
// Build option: define MULDIV_DIV_EN to include restoring division; otherwise DIVU completes at once with zero results.
module alu_muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dz_o
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opnd;
  logic        r_dz;

  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [3:0]  w_ctrl;
  logic        w_carry;

  // Carry out of the 32-bit add is recovered from unsigned wrap-around.
  assign w_carry = (alu_result_i < r_hi);

`ifdef MULDIV_DIV_EN
  logic [31:0] w_sh;
  logic        w_ge;

  // HI[31] set means the shifted remainder exceeds 32 bits, so it always covers D.
  assign w_sh = {r_hi[30:0], r_lo[31]};
  assign w_ge = r_hi[31] | (w_sh >= r_opnd);
`endif

  always_comb begin
    w_src1 = 32'd0;
    w_src2 = 32'd0;
    w_ctrl = 4'b0000;
    case (r_state)
      S_MUL: begin
        w_src1 = r_hi;
        w_src2 = r_lo[0] ? r_opnd : 32'd0;
        w_ctrl = ALU_ADD;
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        w_src1 = w_sh;
        w_src2 = r_opnd;
        w_ctrl = ALU_SUB;
      end
`endif
      default: begin
        w_src1 = 32'd0;
        w_src2 = 32'd0;
        w_ctrl = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_opnd  <= 32'd0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_cnt  <= 5'd0;
            r_dz   <= 1'b0;
            r_opnd <= b_i;
            if (!op_i) begin
              r_hi    <= 32'd0;
              r_lo    <= a_i;
              r_state <= S_MUL;
            end else begin
`ifdef MULDIV_DIV_EN
              if (b_i == 32'd0) begin
                r_hi    <= a_i;
                r_lo    <= 32'hFFFF_FFFF;
                r_dz    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_hi    <= 32'd0;
                r_lo    <= a_i;
                r_state <= S_DIV;
              end
`else
              r_hi    <= 32'd0;
              r_lo    <= 32'd0;
              r_state <= S_DONE;
`endif
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          // Shift-add: the sum's carry and LSB fall into HI/LO as the pair shifts right.
          r_hi  <= {w_carry, alu_result_i[31:1]};
          r_lo  <= {alu_result_i[0], r_lo[31:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          r_hi  <= w_ge ? alu_result_i : w_sh;
          r_lo  <= {r_lo[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_src1_o = w_src1;
  assign alu_src2_o = w_src2;
  assign alu_ctrl_o = w_ctrl;
  assign busy_o     = (r_state == S_MUL) || (r_state == S_DIV);
  assign done_o     = (r_state == S_DONE);
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign dz_o       = r_dz;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU plus an arithmetic reference model (honours MULDIV_DIV_EN).
module tb_alu_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        op_i = 1'b0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        dz_o;

  int n_total = 0;
  int n_pass  = 0;

  alu_muldiv_seq dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .dz_o         (dz_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared ALU stand-in: SUB on 0110, otherwise ADD.
  assign alu_result_i = (alu_ctrl_o == 4'b0110) ? (alu_src1_o - alu_src2_o)
                                                : (alu_src1_o + alu_src2_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output int lat);
    logic [63:0] p;
    if (!op) begin
      p = {32'd0, a} * {32'd0, b};
      hi = p[63:32]; lo = p[31:0]; dz = 1'b0; lat = 33;
    end
`ifdef MULDIV_DIV_EN
    else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; lat = 1;
    end else begin
      hi = a % b; lo = a / b; dz = 1'b0; lat = 33;
    end
`else
    else begin
      hi = 32'd0; lo = 32'd0; dz = 1'b0; lat = 1;
    end
`endif
  endfunction

  // Watch one operation from the cycle after acceptance until done_o, then check everything.
  task automatic watch(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic        edz;
    int          elat, ebusy, busy_n, ctrl_ok, done_at;
    logic [3:0]  ectrl;
    model(op, a, b, eh, el, edz, elat);
    ebusy   = (elat == 33) ? 32 : 0;
    ectrl   = op ? 4'b0110 : 4'b0010;
    busy_n  = 0;
    ctrl_ok = 0;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(negedge clk_i);
      if (busy_o) begin
        busy_n++;
        if (alu_ctrl_o == ectrl) ctrl_ok++;
      end
      if (done_o) done_at = c;
    end
    chk({tag, "_latency"}, done_at, elat);
    chk({tag, "_busy_cycles"}, busy_n, ebusy);
    chk({tag, "_ctrl_cycles"}, ctrl_ok, ebusy);
    chk({tag, "_hi"}, hi_o, eh);
    chk({tag, "_lo"}, lo_o, el);
    chk({tag, "_dz"}, dz_o, edz);
  endtask

  task automatic do_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    watch(tag, op, a, b);
    @(negedge clk_i);
    chk({tag, "_done_pulse_end"}, done_o, 1'b0);
  endtask

  initial begin
    logic        bop [5];
    logic [31:0] ba  [5];
    logic [31:0] bb  [5];
    int          busy_seen;

    // Reset state, before any clock edge.
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_alu", {alu_src1_o, alu_src2_o}, 64'd0);
    chk("rst_ctrl_dz", {alu_ctrl_o, dz_o}, 5'd0);
    @(negedge clk_i); rst_n = 1'b1;

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = 1'b0; a_i = 32'h8765_4321; b_i = 32'h0000_F00D;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 40 && busy_seen < 10; c++) begin
      @(negedge clk_i);
      if (busy_o) busy_seen++;
    end
    chk("midmul_busy_before_reset", busy_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done", done_o, 1'b0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_alu", {alu_src1_o, alu_src2_o}, 64'd0);
    chk("midrst_ctrl_dz", {alu_ctrl_o, dz_o}, 5'd0);
    @(negedge clk_i); rst_n = 1'b1;
    do_op("mul_3x5", 1'b0, 32'd3, 32'd5);

    // Directed boundary operands.
    do_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div_100_7", 1'b1, 32'd100, 32'd7);
    do_op("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1);
    do_op("div_msb", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div_by_zero", 1'b1, 32'd1234, 32'd0);
    do_op("mul_after_dz", 1'b0, 32'd7, 32'd6);

    // Randomized operations.
    for (int i = 0; i < 6; i++) begin
      logic        rop;
      logic [31:0] ra, rb;
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 1000));
      do_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    // start_i held high: each new operation is accepted on the DONE cycle.
    bop[0] = 1'b0; ba[0] = $urandom; bb[0] = $urandom;
    bop[1] = 1'b1; ba[1] = $urandom; bb[1] = $urandom_range(1, 5000);
    bop[2] = 1'b0; ba[2] = $urandom; bb[2] = $urandom;
    bop[3] = 1'b1; ba[3] = $urandom; bb[3] = $urandom;
    bop[4] = 1'b0; ba[4] = $urandom; bb[4] = $urandom;
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = bop[0]; a_i = ba[0]; b_i = bb[0];
    @(posedge clk_i);
    for (int k = 0; k < 5; k++) begin
      watch($sformatf("b2b%0d", k), bop[k], ba[k], bb[k]);
      // Still inside the DONE cycle: present the next request (or drop start).
      if (k < 4) begin
        op_i = bop[k+1]; a_i = ba[k+1]; b_i = bb[k+1];
      end else begin
        start_i = 1'b0;
      end
    end
    @(negedge clk_i);
    chk("b2b_idle_after", {busy_o, done_o}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
